sobel_janela: RTL



---
 rtl/sobel_janela.sv | 138 +++++++++++++
 1 files changed

// File: rtl/sobel_janela.sv
// sobel_janela: 3x3 neighbourhood generator (two line buffers + column shift register) feeding the Sobel core.
// Optional macro SOBEL_JANELA_CONTADOR_EN adds the db_num_janelas accepted-window counter.
module sobel_janela #(
  parameter int LARGURA = 64,
  parameter int ALTURA  = 64,
  parameter int CW      = 7,
  parameter int RW      = 7
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [7:0]    pixel_in,
  input  logic          pixel_valid,
  output logic          pixel_ready,
  output logic [71:0]   janela,
  output logic          janela_valida,
  input  logic          janela_aceita,
  output logic          fim_imagem,
  output logic [RW-1:0] db_linha,
  output logic [CW-1:0] db_coluna,
  output logic [1:0]    db_estado
`ifdef SOBEL_JANELA_CONTADOR_EN
  ,
  output logic [15:0]   db_num_janelas
`endif
);

  localparam int AW = (LARGURA > 1) ? $clog2(LARGURA) : 1;

  typedef enum logic [1:0] {
    ENCHE  = 2'd0,
    OPERA  = 2'd1,
    ESPERA = 2'd2
  } estado_t;

  estado_t       estado, estado_n;
  logic [RW-1:0] linha, linha_n;
  logic [CW-1:0] coluna, coluna_n;
  logic [AW-1:0] idx;
  logic [7:0]    lb0 [LARGURA];
  logic [7:0]    lb1 [LARGURA];
  // Each column is {row r-2, row r-1, row r}; col2 is the newest.
  logic [23:0]   col0, col1, col2, col_nova;
  logic          aceito, fim_col, fim_lin, gera, ultimo_px;

  assign idx       = coluna[AW-1:0];
  assign fim_col   = (coluna == CW'(LARGURA - 1));
  assign fim_lin   = (linha == RW'(ALTURA - 1));
  assign aceito    = pixel_valid & pixel_ready;
  assign gera      = aceito & (linha >= RW'(2)) & (coluna >= CW'(2));
  assign ultimo_px = aceito & fim_col & fim_lin;
  assign col_nova  = {lb1[idx], lb0[idx], pixel_in};

  assign pixel_ready   = reset & (~janela_valida | janela_aceita);
  assign janela_valida = (estado == ESPERA);
  assign janela        = {col0[23:16], col1[23:16], col2[23:16],
                          col0[15:8],  col1[15:8],  col2[15:8],
                          col0[7:0],   col1[7:0],   col2[7:0]};

  assign db_linha  = linha;
  assign db_coluna = coluna;
  assign db_estado = estado;

  always_comb begin
    coluna_n = coluna;
    linha_n  = linha;
    if (aceito) begin
      if (fim_col) begin
        coluna_n = '0;
        linha_n  = fim_lin ? '0 : linha + 1'b1;
      end else begin
        coluna_n = coluna + 1'b1;
      end
    end
  end

  always_comb begin
    estado_n = estado;
    case (estado)
      ENCHE:  if (aceito && linha == RW'(1) && fim_col) estado_n = OPERA;
      OPERA: begin
        if (gera)           estado_n = ESPERA;
        else if (ultimo_px) estado_n = ENCHE;
      end
      ESPERA: begin
        // Full throughput: a same-cycle window-producing accept keeps us here.
        if (gera)               estado_n = ESPERA;
        else if (janela_aceita) estado_n = (linha_n < RW'(2)) ? ENCHE : OPERA;
      end
      default: estado_n = ENCHE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado     <= ENCHE;
      linha      <= '0;
      coluna     <= '0;
      fim_imagem <= 1'b0;
      col0       <= '0;
      col1       <= '0;
      col2       <= '0;
    end else begin
      estado     <= estado_n;
      linha      <= linha_n;
      coluna     <= coluna_n;
      fim_imagem <= ultimo_px;
      if (aceito) begin
        col0 <= col1;
        col1 <= col2;
        col2 <= col_nova;
      end
    end
  end

  // Line buffers need no reset: rows 0 and 1 never emit windows.
  always_ff @(posedge clock) begin
    if (aceito) begin
      lb1[idx] <= lb0[idx];
      lb0[idx] <= pixel_in;
    end
  end

`ifdef SOBEL_JANELA_CONTADOR_EN
  logic janela_tomada;
  assign janela_tomada = janela_valida & janela_aceita;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      db_num_janelas <= '0;
    end else if (fim_imagem) begin
      db_num_janelas <= {15'd0, janela_tomada};
    end else if (janela_tomada && db_num_janelas != '1) begin
      db_num_janelas <= db_num_janelas + 1'b1;
    end
  end
`endif

endmodule
